// File: rtl/fetch_ctrl.sv
`default_nettype none
// fetch_ctrl: instruction fetch controller with one request in flight at a time
// and a single buffered slot presented to decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        f_stall,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst,
    output logic        inst_exc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        stale_q, stale_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_exc_q, inst_exc_d;
    logic        pc_misaligned;

    assign pc_misaligned = |pc_q[1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            stale_q    <= 1'b0;
            inst_q     <= 32'h0;
            inst_pc_q  <= 32'h0;
            inst_exc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            stale_q    <= stale_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            inst_exc_q <= inst_exc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        stale_d    = stale_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_exc_d = inst_exc_q;

        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    // A request accepted in this same cycle is still in flight; its data must be dropped.
                    if (!pc_misaligned && ireq_addr_ok) begin
                        stale_d = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (pc_misaligned) begin
                    inst_d     = 32'h0;
                    inst_pc_d  = pc_q;
                    inst_exc_d = 1'b1;
                    state_d    = S_HOLD;
                end else if (ireq_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (iresp_data_ok) begin
                        stale_d = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        stale_d = 1'b1;
                    end
                end else if (iresp_data_ok) begin
                    if (stale_q) begin
                        stale_d = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d     = iresp_data;
                        inst_pc_d  = pc_q;
                        inst_exc_d = 1'b0;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (!f_stall) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Gating with resetn keeps the request line low for the whole reset interval.
    assign ireq_valid = resetn && (state_q == S_REQ) && !pc_misaligned;
    assign ireq_addr  = pc_q;
    assign inst_valid = (state_q == S_HOLD);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_exc   = inst_exc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// tb_fetch_ctrl: directed scenarios for fetch_ctrl; expected decode slots are
// queued when responses are driven and popped when the slot is presented.
module tb_fetch_ctrl;

    logic        clk;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        f_stall;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        inst_exc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        exc;
    } slot_t;

    slot_t sb[$];
    int    n_pass;
    int    n_total;

    fetch_ctrl #(.RESET_PC(32'hbfc0_0000)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .f_stall       (f_stall),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .ireq_addr_ok  (ireq_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .inst_valid    (inst_valid),
        .inst_pc       (inst_pc),
        .inst          (inst),
        .inst_exc      (inst_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_slot(input logic [31:0] pc, input logic [31:0] word, input logic exc);
        slot_t s;
        s.pc   = pc;
        s.word = word;
        s.exc  = exc;
        sb.push_back(s);
    endtask

    task automatic expect_inst(input string tag);
        slot_t s;
        chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'h0, 32'h1);
        end else begin
            s = sb.pop_front();
            chk({tag, "_pc"},   inst_pc, s.pc);
            chk({tag, "_inst"}, inst, s.word);
            chk({tag, "_exc"},  {31'h0, inst_exc}, {31'h0, s.exc});
        end
    endtask

    // Issue at the current PC with addr_ok immediately and data_ok on the next cycle.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] word);
        chk({tag, "_ireq_valid"}, {31'h0, ireq_valid}, 32'h1);
        chk({tag, "_ireq_addr"}, ireq_addr, addr);
        ireq_addr_ok = 1'b1;
        step();
        ireq_addr_ok  = 1'b0;
        iresp_data_ok = 1'b1;
        iresp_data    = word;
        push_slot(addr, word, 1'b0);
        step();
        iresp_data_ok = 1'b0;
        iresp_data    = 32'h0;
        expect_inst(tag);
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        resetn         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        f_stall        = 1'b0;
        ireq_addr_ok   = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = 32'h0;

        #2;
        chk("rst_ireq_valid", {31'h0, ireq_valid}, 32'h0);
        chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_exc", {31'h0, inst_exc}, 32'h0);
        step();
        step();
        resetn = 1'b1;
        #1;

        // Basic fetch with minimum latency, then sequential advance.
        fetch("f0", 32'hbfc0_0000, 32'h2402_0001);
        step();
        chk("f0_next_addr", ireq_addr, 32'hbfc0_0004);
        chk("f0_next_valid", {31'h0, ireq_valid}, 32'h1);

        // Decode stalls for three cycles; a stray data_ok in HOLD must be ignored.
        fetch("f1", 32'hbfc0_0004, 32'h1111_1111);
        f_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iresp_data_ok = (i == 1);
            iresp_data    = 32'h5555_5555;
            step();
            chk("stall_valid", {31'h0, inst_valid}, 32'h1);
            chk("stall_pc", inst_pc, 32'hbfc0_0004);
            chk("stall_inst", inst, 32'h1111_1111);
            chk("stall_noreq", {31'h0, ireq_valid}, 32'h0);
        end
        iresp_data_ok = 1'b0;
        f_stall = 1'b0;
        step();
        chk("stall_next_addr", ireq_addr, 32'hbfc0_0008);

        // Redirect coincident with addr_ok: the response in flight is stale.
        ireq_addr_ok   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        ireq_addr_ok   = 1'b0;
        redirect_valid = 1'b0;
        chk("stale_wait_noreq", {31'h0, ireq_valid}, 32'h0);
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hdead_beef;
        step();
        iresp_data_ok = 1'b0;
        chk("stale_dropped", {31'h0, inst_valid}, 32'h0);
        chk("stale_next_addr", ireq_addr, 32'h8000_0100);
        fetch("f2", 32'h8000_0100, 32'h3c1d_8000);
        step();

        // Redirect in REQ without acceptance.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step();
        redirect_valid = 1'b0;
        chk("req_redir_addr", ireq_addr, 32'h8000_0200);
        chk("req_redir_valid", {31'h0, ireq_valid}, 32'h1);

        // Two redirects while waiting: the last target wins and the response is discarded.
        ireq_addr_ok = 1'b1;
        step();
        ireq_addr_ok   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        step();
        redirect_pc = 32'h8000_0400;
        step();
        redirect_valid = 1'b0;
        iresp_data_ok  = 1'b1;
        iresp_data     = 32'hbadb_ad00;
        step();
        iresp_data_ok = 1'b0;
        chk("wait_redir_drop", {31'h0, inst_valid}, 32'h0);
        chk("wait_redir_addr", ireq_addr, 32'h8000_0400);

        // Redirect coincident with data_ok: data discarded, no lingering stale flag.
        ireq_addr_ok = 1'b1;
        step();
        ireq_addr_ok   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0500;
        iresp_data_ok  = 1'b1;
        iresp_data     = 32'h7777_7777;
        step();
        redirect_valid = 1'b0;
        iresp_data_ok  = 1'b0;
        chk("coinc_drop", {31'h0, inst_valid}, 32'h0);
        chk("coinc_addr", ireq_addr, 32'h8000_0500);
        fetch("f3", 32'h8000_0500, 32'haaaa_5555);

        // Redirect in HOLD beats f_stall; misaligned target raises an exception slot.
        f_stall        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0002;
        step();
        redirect_valid = 1'b0;
        f_stall        = 1'b0;
        chk("hold_redir_drop", {31'h0, inst_valid}, 32'h0);
        chk("misal_noreq", {31'h0, ireq_valid}, 32'h0);
        push_slot(32'h8000_0002, 32'h0, 1'b1);
        step();
        expect_inst("exc");
        chk("exc_noreq", {31'h0, ireq_valid}, 32'h0);

        // Redirect beats the sequential PC+4, then PC wraps past the top of memory.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hffff_fffc;
        step();
        redirect_valid = 1'b0;
        fetch("f4", 32'hffff_fffc, 32'h1234_5678);
        step();
        chk("wrap_addr", ireq_addr, 32'h0000_0000);
        chk("wrap_valid", {31'h0, ireq_valid}, 32'h1);

        // Reset while waiting clears outputs immediately; a late data_ok is ignored.
        ireq_addr_ok = 1'b1;
        step();
        ireq_addr_ok = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_ireq_valid", {31'h0, ireq_valid}, 32'h0);
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_inst_pc", inst_pc, 32'h0);
        step();
        resetn = 1'b1;
        #1;
        chk("post_rst_addr", ireq_addr, 32'hbfc0_0000);
        chk("post_rst_valid", {31'h0, ireq_valid}, 32'h1);
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hcafe_f00d;
        step();
        iresp_data_ok = 1'b0;
        chk("late_data_ignored", {31'h0, inst_valid}, 32'h0);
        fetch("f5", 32'hbfc0_0000, 32'h0000_0000);
        step();
        chk("f5_next_addr", ireq_addr, 32'hbfc0_0004);
        chk("sb_drained", sb.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc0_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 redirect_valid  input  1  branch/exception redirect request, single-cycle.
REQ-005 redirect_pc  input  32  redirect target, sampled when redirect_valid=1.
REQ-006 f_stall  input  1  decode cannot accept the presented instruction.
REQ-007 ireq_valid  output  1  instruction-memory request valid.
REQ-008 ireq_addr  output  32  instruction-memory request address.
REQ-009 ireq_addr_ok  input  1  memory accepted the request this cycle.
REQ-010 iresp_data_ok  input  1  response data valid this cycle.
REQ-011 iresp_data  input  32  response instruction word.
REQ-012 inst_valid  output  1  instruction presented to decode.
REQ-013 inst_pc  output  32  PC of the presented instruction.
REQ-014 inst  output  32  presented instruction word.
REQ-015 inst_exc  output  1  presented slot carries an address-error (misaligned PC) exception.

Function
REQ-016 Block SHALL hold a PC register and a state machine with states REQ, WAIT, HOLD, plus a 1-bit stale flag.
REQ-017 REQ: ireq_valid=1, ireq_addr=PC, held stable until ireq_addr_ok=1 (unless redirected); on ireq_addr_ok -> WAIT.
REQ-018 REQ with PC[1:0]!=0: ireq_valid SHALL be 0; next state HOLD with inst=0, inst_pc=PC, inst_exc=1.
REQ-019 WAIT: ireq_valid=0; on iresp_data_ok with stale=0 -> capture inst=iresp_data, inst_pc=PC, inst_exc=0, go HOLD.
REQ-020 WAIT: on iresp_data_ok with stale=1 -> discard data, clear stale, go REQ.
REQ-021 HOLD: inst_valid=1, outputs stable; f_stall=0 -> PC<=PC+4 (wrap modulo 2^32), go REQ; f_stall=1 -> stay HOLD.
REQ-022 inst_valid SHALL be 1 only in HOLD; minimum latency from request issue to inst_valid is 2 cycles (addr_ok in issue cycle, data_ok next cycle).
REQ-023 iresp_data_ok outside WAIT SHALL be ignored.
REQ-024 Redirect SHALL have priority over f_stall, ireq_addr_ok completion and iresp_data_ok capture.
REQ-025 Redirect in REQ without ireq_addr_ok: PC<=redirect_pc, stay REQ; ireq_addr shows new PC next cycle.
REQ-026 Redirect in REQ coincident with ireq_addr_ok: PC<=redirect_pc, stale<=1, go WAIT.
REQ-027 Redirect in WAIT without data_ok: PC<=redirect_pc, stale<=1, stay WAIT; repeated redirects: last target wins.
REQ-028 Redirect in WAIT coincident with data_ok: response discarded, PC<=redirect_pc, stale<=0, go REQ.
REQ-029 Redirect in HOLD: buffered slot dropped, inst_valid=0 next cycle, PC<=redirect_pc, go REQ.
REQ-030 At most one request SHALL be outstanding at any time.

Reset
REQ-031 resetn=0 SHALL immediately force: state REQ, PC=RESET_PC, stale=0, inst_valid=0, inst=0, inst_pc=0, inst_exc=0, ireq_valid=0.
REQ-032 First cycle after resetn deasserts: ireq_valid=1, ireq_addr=RESET_PC.
REQ-033 Reset mid-transaction SHALL abandon the outstanding request; a late data_ok arriving in REQ is ignored per REQ-023.

Verification
REQ-034 Reset release, addr_ok immediate, data_ok next cycle with 0x24020001, f_stall=0 -> inst_valid=1, inst_pc=0xbfc00000, inst=0x24020001, then ireq_addr=0xbfc00004.
REQ-035 HOLD with f_stall=1 for 3 cycles -> inst/inst_pc stable, no new ireq_valid; f_stall=0 -> next request at PC+4.
REQ-036 Redirect to 0x80000100 coincident with addr_ok at 0xbfc00008 -> data_ok with 0xdeadbeef never presented; next ireq_addr=0x80000100.
REQ-037 Redirect to 0x80000002 -> no ireq_valid; inst_valid=1, inst_exc=1, inst=0, inst_pc=0x80000002.
REQ-038 PC=0xfffffffc, f_stall=0 -> next ireq_addr=0x00000000; resetn pulsed low while in WAIT -> outputs cleared same cycle, first request at 0xbfc00000.
